// File: rtl/mole_sequencer.sv
// Whack-a-mole round controller: gap, one lit mole, then scoring, repeated until
// the game mode declares the game over. Mole choice comes from a free-running LFSR.

module mole_lane #(
  parameter int LANE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] idx_d,
  input  logic       key_valid,
  input  logic [3:0] key_index,
  output logic       light,
  output logic       match
);
  always_ff @(posedge clk or posedge reset)
    if (reset) light <= 1'b0;
    else       light <= load && (idx_d == 4'(LANE));

  // a lit lane can only exist in ON, so this also gates hits to the ON window
  assign match = light && key_valid && (key_index == 4'(LANE));
endmodule

module mole_sequencer #(
  parameter int CNT_W      = 28,
  parameter int N_LIGHTS   = 9,
  parameter int SCORE_W    = 6,
  parameter int LEVEL_HITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [SCORE_W-1:0]  total_flicks,
  input  logic [CNT_W-1:0]    light_on_cycles,
  input  logic [CNT_W-1:0]    light_between_cycles,
  input  logic                load_seed,
  input  logic [15:0]         seed,
  input  logic                key_valid,
  input  logic [3:0]          key_index,
  output logic [N_LIGHTS-1:0] lights,
  output logic [SCORE_W-1:0]  hits,
  output logic [SCORE_W-1:0]  misses,
  output logic [SCORE_W-1:0]  flicks,
  output logic [1:0]          level,
  output logic                busy,
  output logic                game_over
);
  typedef enum logic [2:0] {S_IDLE, S_GAP, S_ON, S_SCORE, S_DONE} state_t;

  localparam logic [1:0]         M_DEATH  = 2'd1;
  localparam logic [1:0]         M_CONT   = 2'd2;
  localparam logic [15:0]        SEED_DEF = 16'hACE1;
  localparam logic [SCORE_W-1:0] STEP     = SCORE_W'(LEVEL_HITS);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, on_q, gap_q, eff_on;
  logic [15:0]        lfsr;
  logic               fb;
  logic [3:0]         raw, fold, pick, idx_q, prev_idx, idx_d;
  logic [1:0]         mode_q;
  logic [SCORE_W-1:0] total_q, hits_nx, misses_nx, flicks_nx;
  logic               was_hit, hit, lvl_up;
  logic [N_LIGHTS-1:0] match_v;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + SCORE_W'(1);
  endfunction

  assign fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign eff_on = on_q >> level;
  assign hit    = |match_v;
  assign raw    = lfsr[3:0];

  // fold the 4-bit draw onto 0..8, then nudge off the previous mole
  always_comb begin
    fold = (raw >= 4'd9) ? raw - 4'd9 : raw;
    pick = fold;
    if (fold == prev_idx) pick = (fold == 4'd8) ? 4'd0 : fold + 4'd1;
  end

  always_comb begin
    hits_nx   = was_hit ? sat_inc(hits) : hits;
    misses_nx = was_hit ? misses : sat_inc(misses);
    flicks_nx = sat_inc(flicks);
    lvl_up    = (mode_q == M_CONT) && was_hit && (hits_nx != '0) &&
                ((hits_nx % STEP) == '0) && (level != 2'd3);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else       state <= state_d;

  always_comb begin
    state_d = state;
    case (state)
      S_GAP:   if (cnt == '0) state_d = S_ON;
      S_ON:    if (hit || (key_valid && mode_q == M_DEATH) || cnt == '0) state_d = S_SCORE;
      S_SCORE: state_d = ((flicks_nx == total_q) || (mode_q == M_DEATH && !was_hit)) ?
                         S_DONE : S_GAP;
      default: ;
    endcase
    if (start) state_d = S_GAP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr      <= SEED_DEF;
      cnt       <= '0;
      on_q      <= '0;
      gap_q     <= '0;
      mode_q    <= '0;
      total_q   <= '0;
      idx_q     <= '0;
      prev_idx  <= '0;
      was_hit   <= 1'b0;
      hits      <= '0;
      misses    <= '0;
      flicks    <= '0;
      level     <= '0;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      if (load_seed && (state == S_IDLE || state == S_DONE))
        lfsr <= (seed == 16'd0) ? SEED_DEF : seed;
      else
        lfsr <= {lfsr[14:0], fb};
      busy      <= state_d inside {S_GAP, S_ON, S_SCORE};
      game_over <= (state_d == S_DONE);
      if (start) begin
        mode_q   <= mode;
        total_q  <= (total_flicks == '0) ? SCORE_W'(1) : total_flicks;
        on_q     <= light_on_cycles;
        gap_q    <= light_between_cycles;
        cnt      <= light_between_cycles;
        prev_idx <= '0;
        was_hit  <= 1'b0;
        hits     <= '0;
        misses   <= '0;
        flicks   <= '0;
        level    <= '0;
      end else begin
        case (state)
          S_GAP:
            if (cnt == '0) begin
              cnt      <= eff_on;
              idx_q    <= pick;
              prev_idx <= pick;
            end else cnt <= cnt - CNT_W'(1);
          S_ON:
            if (state_d == S_SCORE) was_hit <= hit;
            else                    cnt     <= cnt - CNT_W'(1);
          S_SCORE: begin
            hits   <= hits_nx;
            misses <= misses_nx;
            flicks <= flicks_nx;
            if (lvl_up) level <= level + 2'd1;
            cnt    <= gap_q;
          end
          default: ;
        endcase
      end
    end
  end

  // lanes latch the new mole on the GAP->ON edge and hold it through ON
  assign idx_d = (state == S_GAP) ? pick : idx_q;

  for (genvar g = 0; g < N_LIGHTS; g++) begin : g_lane
    mole_lane #(.LANE(g)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .load      (state_d == S_ON),
      .idx_d     (idx_d),
      .key_valid (key_valid),
      .key_index (key_index),
      .light     (lights[g]),
      .match     (match_v[g])
    );
  end
endmodule

// File: tb/tb_mole_sequencer.sv
// Directed bench for mole_sequencer: timing windows, scoring, modes, seed and
// start/reset overrides, with a reference LFSR predicting every mole.

module tb_mole_sequencer;
  localparam int CNT_W = 28, SCORE_W = 6, NL = 9;

  logic clk = 1'b0;
  logic reset, start, load_seed, key_valid;
  logic [1:0] mode;
  logic [SCORE_W-1:0] total_flicks;
  logic [CNT_W-1:0] on_c, gap_c;
  logic [15:0] seed;
  logic [3:0] key_index;
  logic [NL-1:0] lights;
  logic [SCORE_W-1:0] hits, misses, flicks;
  logic [1:0] level;
  logic busy, game_over;

  int checks = 0, failures = 0;
  int m_prev = 0, cur_idx = 0;
  logic [15:0] m_lfsr, m_pre;

  always #10 clk = ~clk;

  mole_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .total_flicks(total_flicks), .light_on_cycles(on_c),
    .light_between_cycles(gap_c), .load_seed(load_seed), .seed(seed),
    .key_valid(key_valid), .key_index(key_index), .lights(lights),
    .hits(hits), .misses(misses), .flicks(flicks), .level(level),
    .busy(busy), .game_over(game_over)
  );

  // reference LFSR; the bench only pulses load_seed while the DUT is idle or done
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_lfsr <= 16'hACE1;
      m_pre  <= 16'hACE1;
    end else begin
      m_pre  <= m_lfsr;
      m_lfsr <= load_seed ? ((seed == 16'd0) ? 16'hACE1 : seed)
                          : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_prev = 0;
  endtask

  // waits for the next mole and checks it against the reference draw
  task automatic wait_rise(output int g);
    int e;
    g = 0;
    while (lights == '0 && g < 500) begin
      tick();
      g++;
    end
    if (lights == '0) chk("rise_timeout", 32'(lights), 32'h1);
    e = int'(m_pre[3:0]);
    if (e >= 9) e = e - 9;
    if (e == m_prev) e = (e + 1) % 9;
    m_prev  = e;
    cur_idx = e;
    chk("mole", 32'(lights), 32'(1) << e);
  endtask

  // kind: 0 none, 1 correct key, 2 wrong lit-range key, 3 key 9..15
  task automatic run_on(input int press, input int kind, output int o);
    o = 0;
    while (lights != '0 && o < 500) begin
      if (o == press && kind != 0) begin
        key_valid = 1'b1;
        case (kind)
          1:       key_index = 4'(cur_idx);
          2:       key_index = 4'((cur_idx + 1) % 9);
          default: key_index = (cur_idx <= 6) ? 4'(cur_idx + 9) : 4'd15;
        endcase
      end
      tick();
      key_valid = 1'b0;
      o++;
    end
    chk("score_busy", 32'(busy), 32'h1);
    chk("score_go", 32'(game_over), 32'h0);
    tick();
  endtask

  initial begin
    int g, o;
    reset = 1'b1; start = 1'b0; load_seed = 1'b0; key_valid = 1'b0;
    mode = 2'd0; total_flicks = '0; on_c = '0; gap_c = '0; seed = '0; key_index = '0;
    tick(); tick();
    chk("rst_lights", 32'(lights), 32'h0);
    chk("rst_hits", 32'(hits), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_go", 32'(game_over), 32'h0);
    chk("rst_lfsr", 32'(dut.lfsr), 32'hACE1);
    reset = 1'b0;

    // NORMAL, correct key on the 2nd ON cycle each flick
    mode = 2'd0; gap_c = 28'd2; on_c = 28'd3; total_flicks = 6'd3;
    start_game();
    chk("n_busy", 32'(busy), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      wait_rise(g);
      if (i == 1) chk("n_gap", 32'(g), 32'd3);
      run_on(1, 1, o);
      chk("n_onlen", 32'(o), 32'd2);
      chk("n_hits", 32'(hits), 32'(i));
      chk("n_flicks", 32'(flicks), 32'(i));
    end
    chk("n_misses", 32'(misses), 32'h0);
    chk("n_level", 32'(level), 32'h0);
    chk("n_go", 32'(game_over), 32'h1);
    chk("n_idle_busy", 32'(busy), 32'h0);

    // NORMAL, no matching keys: wrong and out-of-range keys are ignored
    start_game();
    for (int i = 1; i <= 3; i++) begin
      wait_rise(g);
      run_on(1, (i == 1) ? 2 : ((i == 2) ? 3 : 0), o);
      chk("m_onlen", 32'(o), 32'd4);
      chk("m_misses", 32'(misses), 32'(i));
    end
    chk("m_hits", 32'(hits), 32'h0);
    chk("m_go", 32'(game_over), 32'h1);

    // total_flicks of 0 acts as a single flick
    gap_c = 28'd0; on_c = 28'd1; total_flicks = 6'd0;
    start_game();
    wait_rise(g);
    run_on(0, 0, o);
    chk("t0_onlen", 32'(o), 32'd2);
    chk("t0_flicks", 32'(flicks), 32'h1);
    chk("t0_go", 32'(game_over), 32'h1);

    // reset in the middle of an ON window
    gap_c = 28'd2; on_c = 28'd3; total_flicks = 6'd3;
    start_game();
    wait_rise(g);
    run_on(0, 1, o);
    chk("r_hits_pre", 32'(hits), 32'h1);
    wait_rise(g);
    tick();
    reset = 1'b1;
    #1;
    chk("r_lights", 32'(lights), 32'h0);
    chk("r_hits", 32'(hits), 32'h0);
    chk("r_flicks", 32'(flicks), 32'h0);
    chk("r_busy", 32'(busy), 32'h0);
    tick();
    reset = 1'b0;
    m_prev = 0;
    tick();
    chk("r_idle_busy", 32'(busy), 32'h0);
    start_game();
    wait_rise(g);
    chk("r_gap", 32'(g), 32'd3);
    run_on(0, 0, o);

    // DEATHMATCH: a wrong key ends the game
    mode = 2'd1; total_flicks = 6'd10;
    start_game();
    wait_rise(g);
    run_on(0, 2, o);
    chk("d_onlen", 32'(o), 32'd1);
    chk("d_misses", 32'(misses), 32'h1);
    chk("d_flicks", 32'(flicks), 32'h1);
    chk("d_go", 32'(game_over), 32'h1);

    // seed 0 maps to the default; then a real seed drives the next game
    load_seed = 1'b1; seed = 16'h0000;
    tick();
    load_seed = 1'b0;
    chk("seed0", 32'(dut.lfsr), 32'hACE1);
    load_seed = 1'b1; seed = 16'h1234;
    tick();
    load_seed = 1'b0;

    // matching key on the timeout cycle counts as a hit
    mode = 2'd0; gap_c = 28'd1; on_c = 28'd3; total_flicks = 6'd5;
    start_game();
    wait_rise(g);
    chk("s_gap", 32'(g), 32'd2);
    run_on(3, 1, o);
    chk("s_onlen", 32'(o), 32'd4);
    chk("s_hits", 32'(hits), 32'h1);
    chk("s_misses", 32'(misses), 32'h0);

    // start mid-ON beats a same-cycle matching key
    wait_rise(g);
    tick();
    start = 1'b1; key_valid = 1'b1; key_index = 4'(cur_idx);
    tick();
    start = 1'b0; key_valid = 1'b0;
    m_prev = 0;
    chk("x_lights", 32'(lights), 32'h0);
    chk("x_hits", 32'(hits), 32'h0);
    chk("x_flicks", 32'(flicks), 32'h0);
    chk("x_busy", 32'(busy), 32'h1);
    wait_rise(g);
    chk("x_gap", 32'(g), 32'd2);
    run_on(0, 0, o);
    chk("x_misses", 32'(misses), 32'h1);
    chk("x_hits2", 32'(hits), 32'h0);

    // CONTINUITY level steps; the mode input change after start is ignored
    mode = 2'd2; gap_c = 28'd0; on_c = 28'd8; total_flicks = 6'd40;
    start_game();
    mode = 2'd0;
    for (int i = 0; i < 4; i++) begin wait_rise(g); run_on(0, 1, o); end
    chk("c_lvl0", 32'(level), 32'h0);
    wait_rise(g); run_on(0, 1, o);
    chk("c_lvl1", 32'(level), 32'h1);
    wait_rise(g); run_on(0, 0, o);
    chk("c_on5", 32'(o), 32'd5);
    for (int i = 0; i < 5; i++) begin wait_rise(g); run_on(0, 1, o); end
    chk("c_hits10", 32'(hits), 32'd10);
    chk("c_lvl2", 32'(level), 32'h2);
    wait_rise(g); run_on(0, 0, o);
    chk("c_on3", 32'(o), 32'd3);
    for (int i = 0; i < 20; i++) begin wait_rise(g); run_on(0, 1, o); end
    chk("c_hits30", 32'(hits), 32'd30);
    chk("c_lvl3", 32'(level), 32'h3);
    wait_rise(g); run_on(0, 0, o);
    chk("c_on2", 32'(o), 32'd2);
    chk("c_misses", 32'(misses), 32'd3);
    chk("c_flicks", 32'(flicks), 32'd33);
    chk("c_go", 32'(game_over), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mole_sequencer.md
Name: mole_sequencer

Overview:
- Game-round controller for the whack-a-mole datapath. It sequences each light flick: gap, then one mole lit, then scoring.
- Picks the next mole from an internal LFSR and times the on and gap windows from the difficulty cycle counts.
- Judges keypad hits and tracks hits, misses, flicks and level. Declares game over per the selected game mode.
- Sits between the switch-decoded settings and keypad decoder on one side and the 9-LED light bank on the other.

Parameters:
- CNT_W, 28, width of the on/gap cycle counters.
- N_LIGHTS, 9, number of moles/LEDs. Fixed at 9; the index logic below depends on it.
- SCORE_W, 6, width of the hit, miss and flick counters.
- LEVEL_HITS, 5, hits per level step in CONTINUITY mode.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  single-cycle pulse; begins or restarts a game.
- mode  in  2  game mode: 0 NORMAL, 1 DEATHMATCH, 2 CONTINUITY, 3 treated as NORMAL.
- total_flicks  in  SCORE_W  number of flicks per game.
- light_on_cycles  in  CNT_W  on-window cycle count N; the window lasts N+1 cycles.
- light_between_cycles  in  CNT_W  gap cycle count M; the gap lasts M+1 cycles.
- load_seed  in  1  load seed into the LFSR.
- seed  in  16  LFSR seed value.
- key_valid  in  1  single-cycle pulse: a key was pressed.
- key_index  in  4  pressed key, 0..8; values 9..15 are never a match.
- lights  out  N_LIGHTS  one-hot lit mole, or all zero.
- hits  out  SCORE_W  hit count.
- misses  out  SCORE_W  miss count.
- flicks  out  SCORE_W  completed flicks.
- level  out  2  current level, CONTINUITY mode only; 0 otherwise.
- busy  out  1  high in GAP, ON and SCORE.
- game_over  out  1  high in DONE.

Behaviour:
- Reset values:
  - State IDLE.
  - lights, hits, misses, flicks, level all 0; busy=0; game_over=0.
  - LFSR=16'hACE1; prev_idx=0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, shifts left.
  - Advances every cycle in every state, so player timing adds randomness.
  - load_seed is honoured only in IDLE or DONE and takes priority over the shift.
  - A seed of 0 loads 16'hACE1.
- Mole index:
  - Computed on GAP exit: raw = lfsr[3:0]; idx = raw - 9 if raw >= 9, else raw.
  - If idx == prev_idx, idx = (idx + 1) mod 9.
  - prev_idx <= idx.
- Config latch:
  - On start, latch mode, total_flicks and both cycle counts.
  - total_flicks = 0 is latched as 1.
  - Input changes mid-game have no effect.
- Effective on-time = latched light_on_cycles >> level. The gap is unscaled.
- States:
  - IDLE: lights=0. start -> GAP.
  - GAP: the counter loads M on entry, decrements each cycle, and exits when it reads 0 (M+1 cycles) -> ON. Keys are ignored.
  - ON:
    - lights = 1 << idx; the counter loads the effective on-time.
    - key_valid with key_index == idx -> hit; go to SCORE next cycle.
    - Wrong key: ignored in NORMAL and CONTINUITY; counted as a miss in DEATHMATCH (go to SCORE).
    - Counter reads 0 with no hit -> miss; go to SCORE.
  - SCORE (1 cycle):
    - lights=0. Increment hits or misses, and flicks. All counters saturate at 2^SCORE_W - 1.
    - CONTINUITY: when the new hits is a nonzero multiple of LEVEL_HITS, level increments, saturating at 3.
    - Go to DONE if the new flicks == total, or if DEATHMATCH and this was a miss; otherwise go to GAP.
  - DONE: lights=0; game_over=1; counters hold. start -> GAP.
- start behaviour:
  - start in any state: clear hits, misses, flicks, level and prev_idx; re-latch config; go to GAP next cycle.
  - start beats a same-cycle key_valid or timeout.
- Simultaneous events:
  - A matching key on the same cycle the ON counter reads 0 counts as a hit.
  - key_valid outside ON is ignored.
- Output timing: all outputs are registered. lights goes high on the first ON cycle and low on the SCORE cycle.
- Reset asserted mid-game returns immediately to the reset values; the latched config is cleared.

Test Plan:
- Reset mid-ON (lights nonzero) -> lights=0, hits=misses=flicks=0, state IDLE. After release, start gives GAP of M+1 cycles.
- NORMAL, M=2, N=3, total=3, no keys -> each ON window is 4 cycles with one-hot lights that never repeat consecutively. After 3 flicks: misses=3, hits=0, game_over=1.
- NORMAL, correct key on the 2nd ON cycle for every flick, total=3 -> hits=3, misses=0. SCORE follows the key by 1 cycle; game_over=1.
- DEATHMATCH, total=10, wrong key in the first ON -> misses=1, flicks=1, game_over=1 two cycles after the key.
- CONTINUITY, N=8, LEVEL_HITS=5, 10 hits -> level=1 after hit 5 (ON window 5 cycles) and level=2 after hit 10 (3 cycles). Then 20 more hits -> level saturates at 3.
- Seed 0 loaded, then start -> LFSR holds 16'hACE1. Matching key and timeout on the same cycle -> hit counted. start mid-ON -> counters cleared and GAP entered.
